// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter onto a single UART TX byte stream
// A grant is held for a whole packet (last, burst limit or idle timeout); output path is one register.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int MAX_BURST    = 16,
   parameter int IDLE_TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [7:0]                 to_uart_data,
   output logic                       to_uart_valid,
   output logic                       to_uart_error,
   input  logic                       to_uart_ready,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       busy
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, XFER} state_e;

   state_e        state_q, state_d;
   logic [GW-1:0] rr_ptr_q, rr_ptr_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [BW-1:0] burst_q, burst_d;
   logic [7:0]    idle_q, idle_d;
   logic          out_valid_q, out_valid_d;
   logic [7:0]    out_data_q, out_data_d;

   logic          pick_found;
   logic [GW-1:0] pick_idx;
   logic          can_load;
   logic          accept;
   logic          uart_xfer;
   logic          release_pkt;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin : rr_search
      logic [GW-1:0] cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      burst_d     = burst_q;
      idle_d      = idle_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      req_ready   = '0;
      accept      = 1'b0;
      release_pkt = 1'b0;
      uart_xfer   = out_valid_q & to_uart_ready;
      can_load    = ~out_valid_q | to_uart_ready;

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = XFER;
               grant_d = pick_idx;
               burst_d = '0;
               idle_d  = '0;
            end
         end
         XFER: begin
            req_ready[grant_q] = can_load;
            accept             = req_valid[grant_q] & can_load;
            if (accept) begin
               burst_d     = burst_q + 1'b1;
               release_pkt = req_last[grant_q] | (burst_q == BW'(MAX_BURST - 1));
            end
            // Counters stop at their threshold because reaching it always releases.
            if (req_valid[grant_q]) begin
               idle_d = '0;
            end else begin
               idle_d = idle_q + 8'd1;
               if (idle_q == 8'(IDLE_TIMEOUT - 1)) begin
                  release_pkt = 1'b1;
               end
            end
            if (release_pkt) begin
               state_d  = IDLE;
               rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = req_data[{grant_q, 3'b000} +: 8];
      end else if (uart_xfer) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         burst_q     <= '0;
         idle_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         burst_q     <= burst_d;
         idle_q      <= idle_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign to_uart_data  = out_data_q;
   assign to_uart_valid = out_valid_q;
   assign to_uart_error = 1'b0;
   assign grant_idx     = grant_q;
   assign busy          = (state_q == XFER) | out_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;

   logic              clk;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic [7:0]        to_uart_data;
   logic              to_uart_valid;
   logic              to_uart_error;
   logic              to_uart_ready;
   logic [1:0]        grant_idx;
   logic              busy;

   uart_tx_arbiter #(.NUM_REQ(NREQ), .MAX_BURST(16), .IDLE_TIMEOUT(64)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .to_uart_data  (to_uart_data),
      .to_uart_valid (to_uart_valid),
      .to_uart_error (to_uart_error),
      .to_uart_ready (to_uart_ready),
      .grant_idx     (grant_idx),
      .busy          (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int fire_cnt    = 0;
   int first_fire  = 0;
   int last_fire   = 0;

   logic [8:0]      src_q [NREQ][$];
   logic [7:0]      exp_q [$];
   logic [NREQ-1:0] fire;
   logic            uart_rdy;
   logic            onehot_bad;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int src, input int seq);
      return 8'(src * 64 + seq);
   endfunction

   task automatic push_pkt(input int src, input int n, input int base, input bit with_last);
      logic l;
      for (int k = 0; k < n; k++) begin
         l = with_last && (k == n - 1);
         src_q[src].push_back({l, pat(src, base + k)});
      end
   endtask

   task automatic exp_pkt(input int src, input int n, input int base);
      for (int k = 0; k < n; k++) exp_q.push_back(pat(src, base + k));
   endtask

   task automatic drive();
      logic [8:0] head;
      for (int i = 0; i < NREQ; i++) begin
         if (src_q[i].size() > 0) begin
            head              = src_q[i][0];
            req_valid[i]      = 1'b1;
            req_data[i*8 +: 8] = head[7:0];
            req_last[i]       = head[8];
         end else begin
            req_valid[i]      = 1'b0;
            req_data[i*8 +: 8] = 8'h00;
            req_last[i]       = 1'b0;
         end
      end
      to_uart_ready = uart_rdy;
   endtask

   task automatic flush();
      for (int i = 0; i < NREQ; i++) src_q[i].delete();
      exp_q.delete();
      fire       = '0;
      onehot_bad = 1'b0;
      drive();
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < NREQ; i++) if (fire[i]) void'(src_q[i].pop_front());
      drive();
      @(negedge clk);
      fire = req_valid & req_ready;
      if ($countones(req_ready) > 1) onehot_bad = 1'b1;
      if (to_uart_valid && to_uart_ready) begin
         if (fire_cnt == 0) first_fire = cyc;
         last_fire = cyc;
         fire_cnt++;
         if (exp_q.size() == 0) check_eq("uart_extra_byte", 32'(to_uart_data), 32'hFFFF_FFFF);
         else check_eq("uart_data", 32'(to_uart_data), 32'(exp_q.pop_front()));
      end
   endtask

   function automatic bit quiet();
      bit q;
      q = (exp_q.size() == 0) && !busy;
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) q = 1'b0;
      return q;
   endfunction

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (!quiet() && n < budget) begin
         tick();
         n++;
      end
      check_eq({tag, "_done"}, 32'(n < budget), 32'd1);
      check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
      check_eq({tag, "_onehot"}, 32'(onehot_bad), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      flush();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      fire_cnt = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1);
   end

   initial begin
      int c0, fv, n, fire1, idle_c, g3;
      logic       stall_ok;
      logic [7:0] held;

      reset    = 1'b0;
      uart_rdy = 1'b1;
      flush();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_uart_valid", 32'(to_uart_valid), 32'd0);
      check_eq("rst_uart_data", 32'(to_uart_data), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_grant_idx", 32'(grant_idx), 32'd0);
      check_eq("rst_uart_error", 32'(to_uart_error), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Single requester, 0x41..0x43, latency and back-to-back output.
      push_pkt(1, 3, 1, 1);
      exp_pkt(1, 3, 1);
      tick();
      c0 = cyc;
      fv = -1;
      n  = 0;
      while (fv < 0 && n < 20) begin
         tick();
         n++;
         if (to_uart_valid) fv = cyc;
      end
      check_eq("t1_first_valid_latency", 32'(fv - c0), 32'd2);
      check_eq("t1_grant_idx", 32'(grant_idx), 32'd1);
      drain("t1", 100);
      check_eq("t1_byte_spacing", 32'(last_fire - first_fire), 32'd2);

      // rr_ptr is now 2: requester 3 beats requester 0.
      push_pkt(0, 1, 8, 1);
      push_pkt(3, 1, 8, 1);
      exp_pkt(3, 1, 8);
      exp_pkt(0, 1, 8);
      drain("t1_rr", 100);

      // All four requesters with 2-byte packets.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         push_pkt(i, 2, 0, 1);
         exp_pkt(i, 2, 0);
      end
      drain("t2", 200);
      check_eq("t2_fire_span", 32'(last_fire - first_fire), 32'd10);

      // Burst limit splits requester 0's unterminated 20-byte stream.
      do_reset();
      push_pkt(0, 20, 0, 0);
      push_pkt(2, 2, 0, 1);
      exp_pkt(0, 16, 0);
      exp_pkt(2, 2, 0);
      exp_pkt(0, 4, 16);
      drain("t3", 400);

      // Backpressure for 5 cycles mid-packet.
      do_reset();
      push_pkt(1, 8, 0, 1);
      exp_pkt(1, 8, 0);
      n = 0;
      while (exp_q.size() > 5 && n < 50) begin
         tick();
         n++;
      end
      uart_rdy = 1'b0;
      stall_ok = 1'b1;
      held     = 8'h00;
      for (int s = 0; s < 5; s++) begin
         tick();
         if (s == 0) held = to_uart_data;
         if (to_uart_data !== held || to_uart_valid !== 1'b1 || req_ready !== '0) stall_ok = 1'b0;
      end
      uart_rdy = 1'b1;
      check_eq("t4_stall_stable", 32'(stall_ok), 32'd1);
      drain("t4", 100);

      // Idle timeout after one byte; requester 3 waits.
      do_reset();
      push_pkt(1, 1, 0, 0);
      push_pkt(3, 2, 0, 1);
      exp_pkt(1, 1, 0);
      exp_pkt(3, 2, 0);
      fire1  = -1;
      idle_c = -1;
      g3     = -1;
      n      = 0;
      while (g3 < 0 && n < 200) begin
         tick();
         n++;
         if (fire1 < 0 && fire[1]) fire1 = cyc;
         else if (fire1 >= 0 && idle_c < 0 && !busy) idle_c = cyc;
         if (fire1 >= 0 && g3 < 0 && req_ready[3]) g3 = cyc;
      end
      check_eq("t5_release_time", 32'(idle_c - fire1), 32'd65);
      check_eq("t5_next_grant_time", 32'(g3 - fire1), 32'd66);
      check_eq("t5_next_grant_idx", 32'(grant_idx), 32'd3);
      drain("t5", 100);

      // Asynchronous reset mid-packet with a byte in the output register.
      push_pkt(2, 2, 0, 1);
      exp_pkt(2, 2, 0);
      drain("t6_pre", 100);
      push_pkt(2, 8, 2, 1);
      exp_pkt(2, 8, 2);
      n = 0;
      while (exp_q.size() > 5 && n < 50) begin
         tick();
         n++;
      end
      check_eq("t6_valid_before_reset", 32'(to_uart_valid), 32'd1);
      #2 reset = 1'b0;
      #1;
      check_eq("t6_rst_uart_valid", 32'(to_uart_valid), 32'd0);
      check_eq("t6_rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("t6_rst_busy", 32'(busy), 32'd0);
      flush();
      @(posedge clk);
      #1 reset = 1'b1;
      push_pkt(3, 1, 20, 1);
      push_pkt(0, 1, 20, 1);
      exp_pkt(0, 1, 20);
      exp_pkt(3, 1, 20);
      drain("t6_post", 100);
      check_eq("t6_last_grant_idx", 32'(grant_idx), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
